// File: rtl/lsu_axi_bridge.sv
// LSU-to-AXI4-Lite bridge: one outstanding read or write per LSU request pulse.
module lsu_axi_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // LSU request side
  input  logic                  req_r_en,
  input  logic                  req_w_en,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_mask,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // AXI read address / data
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI write address / data / response
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                state, state_n;
  logic                  busy_n, rsp_valid_n, rsp_err_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_n, wdata_n;
  logic [ADDR_WIDTH-1:0] araddr_n, awaddr_n;
  logic [STRB_WIDTH-1:0] wstrb_n;
  logic                  arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      araddr    <= araddr_n;
      arvalid   <= arvalid_n;
      rready    <= rready_n;
      awaddr    <= awaddr_n;
      awvalid   <= awvalid_n;
      wdata     <= wdata_n;
      wstrb     <= wstrb_n;
      wvalid    <= wvalid_n;
      bready    <= bready_n;
    end
  end

  // Next-state and next-output logic; a write beats a simultaneous read
  always_comb begin
    state_n     = state;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    araddr_n    = araddr;
    arvalid_n   = arvalid;
    rready_n    = rready;
    awaddr_n    = awaddr;
    awvalid_n   = awvalid;
    wdata_n     = wdata;
    wstrb_n     = wstrb;
    wvalid_n    = wvalid;
    bready_n    = bready;

    case (state)
      IDLE: begin
        if (req_w_en) begin
          state_n   = WR_REQ;
          awaddr_n  = req_addr;
          wdata_n   = req_wdata;
          wstrb_n   = req_mask;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
        end else if (req_r_en) begin
          state_n   = RD_ADDR;
          araddr_n  = req_addr;
          arvalid_n = 1'b1;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          state_n   = RD_DATA;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          state_n     = IDLE;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = rdata;
          rsp_err_n   = (rresp >= 2'd2);
        end
      end
      WR_REQ: begin
        // AW and W retire independently; move on once neither is pending
        if (awready) awvalid_n = 1'b0;
        if (wready)  wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_n     = IDLE;
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = (bresp >= 2'd2);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
